color_palette_db: RTL and testbench

- Parametrised, double-buffered successor to the 8x4 palette block.
- Sits between the Avalon-MM CPU bus and the pixel pipeline.
- CPU writes go to a shadow bank and are copied to the active bank at frame start; this removes mid-frame tearing.
- Adds correct byte-enable writes, registered reads with READDATAVALID, a 2-stage pixel lookup pipeline and an optional transparent-index flag.

---
 rtl/color_palette_db_pkg.sv | 18 +
 rtl/color_palette_db_if.sv | 21 ++
 rtl/color_palette_db_lookup_pipe.sv | 52 +++++
 rtl/color_palette_db.sv | 111 +++++++++++
 tb/tb_color_palette_db.sv | 261 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/color_palette_db_pkg.sv
// Shared constants and the byte-lane merge helper for the double-buffered palette.
package palette_pkg;
  localparam int CTRL_OFF      = 0;
  localparam int TRANSP_OFF    = 1;
  localparam int COMMIT_BIT    = 0;
  localparam int TRANSP_EN_BIT = 1;

  function automatic logic [31:0] byte_merge(input logic [31:0] old_word,
                                             input logic [31:0] new_word,
                                             input logic [3:0]  byte_en);
    logic [31:0] merged;
    merged = old_word;
    for (int i = 0; i < 4; i++) begin
      if (byte_en[i]) merged[8*i +: 8] = new_word[8*i +: 8];
    end
    return merged;
  endfunction
endpackage

// File: rtl/color_palette_db_if.sv
// Avalon-MM slave bus bundle for the colour palette.
interface color_palette_db_if #(parameter int ADDR_W = 6) ();
  logic [ADDR_W-1:0] AVL_ADDR;
  logic [31:0]       AVL_WRITEDATA;
  logic [3:0]        AVL_BYTE_EN;
  logic              AVL_WRITE;
  logic              AVL_READ;
  logic              AVL_CS;
  logic [31:0]       AVL_READDATA;
  logic              AVL_READDATAVALID;

  modport master (
    output AVL_ADDR, AVL_WRITEDATA, AVL_BYTE_EN, AVL_WRITE, AVL_READ, AVL_CS,
    input  AVL_READDATA, AVL_READDATAVALID
  );

  modport slave (
    input  AVL_ADDR, AVL_WRITEDATA, AVL_BYTE_EN, AVL_WRITE, AVL_READ, AVL_CS,
    output AVL_READDATA, AVL_READDATAVALID
  );
endinterface

// File: rtl/color_palette_db_lookup_pipe.sv
// Two-stage pixel lookup: S1 registers the request, S2 reads the active bank.
module palette_lookup_pipe #(
  parameter  int NUM_PALETTES = 8,
  parameter  int NUM_COLORS   = 4,
  parameter  int COLOR_W      = 24,
  localparam int PAL_W        = $clog2(NUM_PALETTES),
  localparam int IDX_W        = $clog2(NUM_COLORS)
) (
  input  logic                                         i_clk,
  input  logic                                         i_rst,
  input  logic [NUM_PALETTES*NUM_COLORS*COLOR_W-1:0]   i_active,
  input  logic                                         i_transp_en,
  input  logic [IDX_W-1:0]                             i_transp_idx,
  input  logic                                         i_valid,
  input  logic [PAL_W-1:0]                             i_palette,
  input  logic [IDX_W-1:0]                             i_index,
  output logic [COLOR_W-1:0]                           o_rgb,
  output logic                                         o_transparent,
  output logic                                         o_valid
);
  logic [PAL_W-1:0]       r_pal;
  logic [IDX_W-1:0]       r_idx;
  logic                   r_vld;
  logic [COLOR_W-1:0]     r_rgb;
  logic                   r_transp;
  logic                   r_vld_out;
  logic [PAL_W+IDX_W-1:0] w_sel;

  assign w_sel = {r_pal, r_idx};

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_pal     <= '0;
      r_idx     <= '0;
      r_vld     <= 1'b0;
      r_rgb     <= '0;
      r_transp  <= 1'b0;
      r_vld_out <= 1'b0;
    end else begin
      r_pal     <= i_palette;
      r_idx     <= i_index;
      r_vld     <= i_valid;
      r_rgb     <= i_active[w_sel*COLOR_W +: COLOR_W];
      r_transp  <= i_transp_en & (r_idx == i_transp_idx);
      r_vld_out <= r_vld;
    end
  end

  assign o_rgb         = r_rgb;
  assign o_transparent = r_transp;
  assign o_valid       = r_vld_out;
endmodule

// File: rtl/color_palette_db.sv
// Double-buffered palette: CPU writes land in shadow, frame_start commits to active.
module color_palette_db
  import palette_pkg::*;
#(
  parameter  int NUM_PALETTES = 8,
  parameter  int NUM_COLORS   = 4,
  parameter  int COLOR_W      = 24,
  localparam int PAL_W        = $clog2(NUM_PALETTES),
  localparam int IDX_W        = $clog2(NUM_COLORS)
) (
  input  logic               CLK_100,
  input  logic               RESET,
  color_palette_db_if.slave  avl,
  input  logic               frame_start,
  input  logic               pix_valid_in,
  input  logic [PAL_W-1:0]   palette,
  input  logic [IDX_W-1:0]   color_index,
  output logic [COLOR_W-1:0] rgb,
  output logic               transparent,
  output logic               pix_valid_out
);
  localparam int ENT_W   = PAL_W + IDX_W;
  localparam int ENTRIES = NUM_PALETTES * NUM_COLORS;

  logic [ENTRIES-1:0][COLOR_W-1:0] r_shadow;
  logic [ENTRIES-1:0][COLOR_W-1:0] r_active;
  logic                            r_pending;
  logic                            r_transp_en;
  logic [IDX_W-1:0]                r_transp_idx;
  logic [31:0]                     r_rddata;
  logic                            r_rdvalid;

  logic             w_wr, w_rd, w_ctrl, w_commit, w_set_commit;
  logic             w_ctrl_wr, w_tidx_wr, w_unused;
  logic [ENT_W-1:0] w_ent;
  logic [31:0]      w_cur, w_merged;

  assign w_wr      = avl.AVL_CS & avl.AVL_WRITE;
  assign w_rd      = avl.AVL_CS & avl.AVL_READ & ~avl.AVL_WRITE;
  assign w_ctrl    = avl.AVL_ADDR[ENT_W];
  assign w_ent     = avl.AVL_ADDR[ENT_W-1:0];
  assign w_ctrl_wr = w_wr & w_ctrl & (w_ent == ENT_W'(CTRL_OFF));
  assign w_tidx_wr = w_wr & w_ctrl & (w_ent == ENT_W'(TRANSP_OFF));
  assign w_commit  = frame_start & r_pending;
  assign w_set_commit = w_ctrl_wr & avl.AVL_BYTE_EN[0] & avl.AVL_WRITEDATA[COMMIT_BIT];

  // Current contents of the addressed word, shared by the read path and byte merge.
  always_comb begin
    w_cur = '0;
    if (!w_ctrl) begin
      w_cur[COLOR_W-1:0] = r_shadow[w_ent];
    end else if (w_ent == ENT_W'(CTRL_OFF)) begin
      w_cur[COMMIT_BIT]    = r_pending;
      w_cur[TRANSP_EN_BIT] = r_transp_en;
    end else if (w_ent == ENT_W'(TRANSP_OFF)) begin
      w_cur[IDX_W-1:0] = r_transp_idx;
    end
  end

  assign w_merged = byte_merge(w_cur, avl.AVL_WRITEDATA, avl.AVL_BYTE_EN);
  assign w_unused = ^w_merged;

  always_ff @(posedge CLK_100 or posedge RESET) begin
    if (RESET) begin
      r_shadow     <= '0;
      r_active     <= '0;
      r_pending    <= 1'b0;
      r_transp_en  <= 1'b0;
      r_transp_idx <= '0;
    end else begin
      if (w_commit) r_active <= r_shadow;
      if (w_wr && !w_ctrl) r_shadow[w_ent] <= w_merged[COLOR_W-1:0];
      if (w_ctrl_wr) r_transp_en <= w_merged[TRANSP_EN_BIT];
      if (w_tidx_wr) r_transp_idx <= w_merged[IDX_W-1:0];
      // A COMMIT write beats the clear so it waits for the following frame_start.
      if (w_set_commit)  r_pending <= 1'b1;
      else if (w_commit) r_pending <= 1'b0;
    end
  end

  always_ff @(posedge CLK_100 or posedge RESET) begin
    if (RESET) begin
      r_rddata  <= '0;
      r_rdvalid <= 1'b0;
    end else begin
      r_rdvalid <= w_rd;
      if (w_rd) r_rddata <= w_cur;
    end
  end

  assign avl.AVL_READDATA      = r_rddata;
  assign avl.AVL_READDATAVALID = r_rdvalid;

  palette_lookup_pipe #(
    .NUM_PALETTES (NUM_PALETTES),
    .NUM_COLORS   (NUM_COLORS),
    .COLOR_W      (COLOR_W)
  ) u_lookup (
    .i_clk         (CLK_100),
    .i_rst         (RESET),
    .i_active      (r_active),
    .i_transp_en   (r_transp_en),
    .i_transp_idx  (r_transp_idx),
    .i_valid       (pix_valid_in),
    .i_palette     (palette),
    .i_index       (color_index),
    .o_rgb         (rgb),
    .o_transparent (transparent),
    .o_valid       (pix_valid_out)
  );
endmodule

// File: tb/tb_color_palette_db.sv
// Self-checking bench: register table vectors plus scoreboarded reads and pixel lookups.
module tb_color_palette_db;
  logic        clk = 1'b0;
  logic        RESET;
  logic        frame_start;
  logic        pix_valid_in;
  logic [2:0]  palette;
  logic [1:0]  color_index;
  logic [23:0] rgb;
  logic        transparent;
  logic        pix_valid_out;

  color_palette_db_if #(.ADDR_W(6)) avl ();

  color_palette_db dut (
    .CLK_100       (clk),
    .RESET         (RESET),
    .avl           (avl),
    .frame_start   (frame_start),
    .pix_valid_in  (pix_valid_in),
    .palette       (palette),
    .color_index   (color_index),
    .rgb           (rgb),
    .transparent   (transparent),
    .pix_valid_out (pix_valid_out)
  );

  always #5 clk = ~clk;

  typedef struct { logic [5:0] addr; logic [31:0] wdata; logic [3:0] be; logic [31:0] exp; } vec_t;
  typedef struct { logic [31:0] data; int cyc; } rd_exp_t;
  typedef struct { logic [23:0] rgb; logic tr; int cyc; } pix_exp_t;

  int checks = 0;
  int failures = 0;
  int cyc = 0;

  rd_exp_t  rq[$];
  pix_exp_t pq[$];
  rd_exp_t  rcur;
  pix_exp_t pcur;

  logic [23:0] m_shadow [32];
  logic [23:0] m_active [32];
  logic        m_pending, m_ten;
  logic [1:0]  m_tidx;

  vec_t vecs [12];

  always @(posedge clk) cyc <= cyc + 1;

  function automatic void chk(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=0x%08h expected=0x%08h (cycle %0d)", name, act, exp, cyc);
    end
  endfunction

  function automatic void model_reset();
    for (int i = 0; i < 32; i++) begin
      m_shadow[i] = '0;
      m_active[i] = '0;
    end
    m_pending = 1'b0;
    m_ten     = 1'b0;
    m_tidx    = '0;
  endfunction

  function automatic logic [31:0] m_read(logic [5:0] a);
    if (!a[5]) return {8'h00, m_shadow[a[4:0]]};
    if (a[4:0] == 5'd0) return {30'd0, m_ten, m_pending};
    if (a[4:0] == 5'd1) return {30'd0, m_tidx};
    return 32'd0;
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
    avl.AVL_CS = 1'b0; avl.AVL_WRITE = 1'b0; avl.AVL_READ = 1'b0;
    avl.AVL_ADDR = '0; avl.AVL_WRITEDATA = '0; avl.AVL_BYTE_EN = '0;
    frame_start = 1'b0; pix_valid_in = 1'b0; palette = '0; color_index = '0;
  endtask

  task automatic set_write(logic [5:0] a, logic [31:0] d, logic [3:0] be);
    avl.AVL_CS = 1'b1; avl.AVL_WRITE = 1'b1;
    avl.AVL_ADDR = a; avl.AVL_WRITEDATA = d; avl.AVL_BYTE_EN = be;
    if (!a[5]) begin
      for (int i = 0; i < 3; i++)
        if (be[i]) m_shadow[a[4:0]][8*i +: 8] = d[8*i +: 8];
    end else if (a[4:0] == 5'd0 && be[0]) begin
      if (d[0]) m_pending = 1'b1;
      m_ten = d[1];
    end else if (a[4:0] == 5'd1 && be[0]) begin
      m_tidx = d[1:0];
    end
  endtask

  task automatic set_read(logic [5:0] a, logic [31:0] exp);
    avl.AVL_CS = 1'b1; avl.AVL_READ = 1'b1; avl.AVL_ADDR = a;
    rq.push_back('{exp, cyc + 1});
  endtask

  task automatic set_read_m(logic [5:0] a);
    set_read(a, m_read(a));
  endtask

  // Call before any same-cycle set_write so the copy sees the pre-write shadow.
  task automatic set_frame();
    frame_start = 1'b1;
    if (m_pending) begin
      m_active  = m_shadow;
      m_pending = 1'b0;
    end
  endtask

  task automatic set_pix(logic [2:0] p, logic [1:0] i);
    palette = p; color_index = i; pix_valid_in = 1'b1;
    pq.push_back('{m_active[{p, i}], m_ten && (i == m_tidx), cyc + 2});
  endtask

  always @(negedge clk) begin
    if (!RESET) begin
      if (avl.AVL_READDATAVALID) begin
        chk("rd_valid_expected", 32'(rq.size() != 0), 32'd1);
        if (rq.size() != 0) begin
          rcur = rq.pop_front();
          chk("rd_data", avl.AVL_READDATA, rcur.data);
          chk("rd_latency", 32'(cyc), 32'(rcur.cyc));
        end
      end
      if (pix_valid_out) begin
        chk("pix_valid_expected", 32'(pq.size() != 0), 32'd1);
        if (pq.size() != 0) begin
          pcur = pq.pop_front();
          chk("pix_rgb", {8'h00, rgb}, {8'h00, pcur.rgb});
          chk("pix_transparent", {31'd0, transparent}, {31'd0, pcur.tr});
          chk("pix_latency", 32'(cyc), 32'(pcur.cyc));
        end
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog expired at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    vecs[0]  = '{6'd5,  32'hAABBCCDD, 4'b0101, 32'h00BB00DD};
    vecs[1]  = '{6'd5,  32'h11223344, 4'b1010, 32'h00BB33DD};
    vecs[2]  = '{6'd0,  32'hFFFFFFFF, 4'b1111, 32'h00FFFFFF};
    vecs[3]  = '{6'd31, 32'h01020304, 4'b0000, 32'h00000000};
    vecs[4]  = '{6'd11, 32'h00123456, 4'b1111, 32'h00123456};
    vecs[5]  = '{6'd25, 32'hDEADBEEF, 4'b0110, 32'h00ADBE00};
    vecs[6]  = '{6'h21, 32'h00000003, 4'b0001, 32'h00000003};
    vecs[7]  = '{6'h21, 32'hFFFFFFFE, 4'b0001, 32'h00000002};
    vecs[8]  = '{6'h22, 32'hFFFFFFFF, 4'b1111, 32'h00000000};
    vecs[9]  = '{6'h20, 32'h00000002, 4'b0001, 32'h00000002};
    vecs[10] = '{6'h20, 32'h00000000, 4'b0001, 32'h00000000};
    vecs[11] = '{6'h20, 32'h00000003, 4'b0000, 32'h00000000};

    model_reset();
    RESET = 1'b1;
    avl.AVL_CS = 1'b0; avl.AVL_WRITE = 1'b0; avl.AVL_READ = 1'b0;
    avl.AVL_ADDR = '0; avl.AVL_WRITEDATA = '0; avl.AVL_BYTE_EN = '0;
    frame_start = 1'b0; pix_valid_in = 1'b0; palette = '0; color_index = '0;
    step(); step();
    chk("reset_readdata", avl.AVL_READDATA, 32'd0);
    chk("reset_readdatavalid", {31'd0, avl.AVL_READDATAVALID}, 32'd0);
    chk("reset_rgb", {8'h00, rgb}, 32'd0);
    chk("reset_pix_valid_out", {31'd0, pix_valid_out}, 32'd0);
    chk("reset_transparent", {31'd0, transparent}, 32'd0);
    RESET = 1'b0;

    step(); set_read(6'd14, 32'd0);
    step(); set_pix(3'd3, 3'd2 == 3'd2 ? 2'd2 : 2'd0);

    foreach (vecs[k]) begin
      step(); set_write(vecs[k].addr, vecs[k].wdata, vecs[k].be);
      step(); set_read(vecs[k].addr, vecs[k].exp);
    end
    step(); set_pix(3'd1, 2'd1);
    step(); step(); step();

    // Commit copies shadow to active and clears pending.
    step(); set_write(6'h20, 32'h1, 4'b0001);
    step(); set_read_m(6'h20);
    step(); set_frame();
    step(); set_read_m(6'h20);
    step(); set_pix(3'd2, 2'd3);
    step(); set_pix(3'd1, 2'd1);
    step(); set_pix(3'd6, 2'd1);
    step(); step(); step();

    // COMMIT write coincident with frame_start waits a frame; S2 sees pre-commit bank.
    step(); set_write(6'd20, 32'h00ABCDEF, 4'b1111);
    step(); set_frame(); set_write(6'h20, 32'h1, 4'b0001);
    step(); set_read_m(6'h20);
    step(); set_pix(3'd5, 2'd0);
    step(); set_frame();
    step(); set_pix(3'd5, 2'd0);
    step(); set_read_m(6'h20);

    // Colour write during a firing commit stays in shadow only.
    step(); set_write(6'h20, 32'h1, 4'b0001);
    step(); set_frame(); set_write(6'd18, 32'h00777777, 4'b1111);
    step(); set_pix(3'd4, 2'd2); set_read_m(6'd18);
    step(); set_read_m(6'h20);
    step(); set_write(6'h20, 32'h1, 4'b0001);
    step(); set_frame(); set_write(6'h20, 32'h1, 4'b0001);
    step(); set_pix(3'd4, 2'd2); set_read_m(6'h20);
    step(); set_frame();
    step(); set_read_m(6'h20);
    step(); step(); step();

    // Read and write together: write wins, no valid.
    step(); set_write(6'd7, 32'h00C0FFEE, 4'b1111); avl.AVL_READ = 1'b1;
    step(); set_read_m(6'd7);
    step(); step();

    // Transparency on index 0.
    step(); set_write(6'h21, 32'h0, 4'b0001);
    step(); set_write(6'h20, 32'h2, 4'b0001);
    step(); set_pix(3'd0, 2'd0);
    step(); set_pix(3'd0, 2'd1);
    step(); set_pix(3'd0, 2'd0);
    step(); step(); step();

    // Asynchronous reset mid-stream with a commit pending.
    step(); set_write(6'd15, 32'h00555555, 4'b1111);
    step(); set_write(6'h20, 32'h3, 4'b0001);
    step(); set_pix(3'd3, 2'd3);
    step(); set_pix(3'd3, 2'd3);
    step(); set_pix(3'd0, 2'd0);
    #2;
    RESET = 1'b1;
    #1;
    chk("async_rst_rgb", {8'h00, rgb}, 32'd0);
    chk("async_rst_transparent", {31'd0, transparent}, 32'd0);
    chk("async_rst_pix_valid_out", {31'd0, pix_valid_out}, 32'd0);
    chk("async_rst_readdata", avl.AVL_READDATA, 32'd0);
    chk("async_rst_readdatavalid", {31'd0, avl.AVL_READDATAVALID}, 32'd0);
    rq.delete();
    pq.delete();
    model_reset();
    step(); step();
    RESET = 1'b0;
    step(); set_frame();
    step(); set_pix(3'd3, 2'd3); set_read_m(6'd15);
    step(); set_read_m(6'h20);
    step(); set_pix(3'd2, 2'd3);
    step(); step(); step(); step();

    chk("rd_queue_drained", 32'(rq.size()), 32'd0);
    chk("pix_queue_drained", 32'(pq.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
